sr_input_conditioner: RTL and testbench

Clocked front end for the team's set/reset latch logic. Takes two raw, asynchronous, active-low set/reset inputs from switches or pads, then synchronizes and debounces them. A small state machine holds the latch state and reproduces NAND-latch semantics, including the forbidden both-asserted case, as clean registered outputs. It sits directly upstream of any logic that consumes a latch Q/Q-bar pair and replaces a free-running cross-coupled gate latch with a synchronous equivalent.

---
 rtl/sr_latch_pkg.sv | 56 +++++
 rtl/sr_debounce.sv | 58 +++++
 rtl/sr_input_conditioner.sv | 99 +++++++++
 tb/tb_sr_input_conditioner.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/sr_latch_pkg.sv
// rtl/sr_latch_pkg.sv - shared types and helpers for the synchronous SR latch front end
//
// Contents:
//   sr_state_e              : latch state encoding (2'b11 is unused and treated as HOLD_RESET)
//   sr_out_t                : decoded latch outputs {q, q_bar, invalid}
//   DEFAULT_DEBOUNCE_CYCLES : default debounce threshold
//   sr_next_state()         : NAND-latch next-state rule
//   sr_decode()             : state to output decode
package sr_latch_pkg;

    typedef enum logic [1:0] {
        HOLD_RESET = 2'b00,
        HOLD_SET   = 2'b01,
        FORBIDDEN  = 2'b10
    } sr_state_e;

    typedef struct packed {
        logic q;
        logic q_bar;
        logic invalid;
    } sr_out_t;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 4;

    // Both requests released out of FORBIDDEN is the classic NAND-latch race;
    // it is resolved to HOLD_RESET so the outcome is deterministic.
    function automatic sr_state_e sr_next_state(input sr_state_e cur,
                                                input logic      set_req,
                                                input logic      reset_req);
        sr_state_e nxt;
        if (set_req && reset_req) begin
            nxt = FORBIDDEN;
        end else if (set_req) begin
            nxt = HOLD_SET;
        end else if (reset_req) begin
            nxt = HOLD_RESET;
        end else begin
            case (cur)
                HOLD_SET: nxt = HOLD_SET;
                default:  nxt = HOLD_RESET;
            endcase
        end
        return nxt;
    endfunction

    function automatic sr_out_t sr_decode(input sr_state_e st);
        sr_out_t o;
        case (st)
            HOLD_SET:  o = '{q: 1'b1, q_bar: 1'b0, invalid: 1'b0};
            FORBIDDEN: o = '{q: 1'b1, q_bar: 1'b1, invalid: 1'b1};
            default:   o = '{q: 1'b0, q_bar: 1'b1, invalid: 1'b0};
        endcase
        return o;
    endfunction

endpackage

// File: rtl/sr_debounce.sv
// rtl/sr_debounce.sv - 2-flop synchronizer plus stable-count debounce for one active-low input
//
// Ports:
//   clk       : system clock, rising edge
//   rst_n     : asynchronous active-low reset
//   raw_n     : raw active-low input, asynchronous to clk
//   filt_nxt  : value the filtered level takes at the coming clock edge
module sr_debounce #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_n,
    output logic filt_nxt
);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             filt_q,  filt_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    always_comb begin
        sync1_d = raw_n;
        sync2_d = sync1_q;
        filt_d  = filt_q;
        cnt_d   = '0;
        if (sync2_q != filt_q) begin
            // The count reaching DEBOUNCE_CYCLES happens on this edge, so
            // compare against one less and commit filt instead of storing it.
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                filt_d = sync2_q;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            filt_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            filt_q  <= filt_d;
            cnt_q   <= cnt_d;
        end
    end

    // The FSM consumes the next filtered value so that the state register
    // moves on the same edge as filt, keeping latency at 2 + DEBOUNCE_CYCLES.
    assign filt_nxt = filt_d;

endmodule

// File: rtl/sr_input_conditioner.sv
// rtl/sr_input_conditioner.sv - synchronized, debounced SR latch with registered NAND-latch outputs
//
// Ports:
//   clk         : system clock, rising edge
//   rst_n       : asynchronous active-low reset
//   s_n_raw     : raw active-low set request
//   r_n_raw     : raw active-low reset request
//   q, q_bar    : latch outputs (both high in FORBIDDEN)
//   set_pulse   : one-cycle strobe on entry to HOLD_SET
//   reset_pulse : one-cycle strobe on entry to HOLD_RESET from another state
//   invalid     : high while in FORBIDDEN
module sr_input_conditioner
    import sr_latch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic s_n_raw,
    input  logic r_n_raw,
    output logic q,
    output logic q_bar,
    output logic set_pulse,
    output logic reset_pulse,
    output logic invalid
);

    logic      filt_s_nxt;
    logic      filt_r_nxt;
    logic      set_req;
    logic      reset_req;
    sr_out_t   dec;

    sr_state_e state_q, state_d;
    logic      q_q, q_d;
    logic      q_bar_q, q_bar_d;
    logic      invalid_q, invalid_d;
    logic      set_pulse_q, set_pulse_d;
    logic      reset_pulse_q, reset_pulse_d;

    sr_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_deb_s (
        .clk      (clk),
        .rst_n    (rst_n),
        .raw_n    (s_n_raw),
        .filt_nxt (filt_s_nxt)
    );

    sr_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_deb_r (
        .clk      (clk),
        .rst_n    (rst_n),
        .raw_n    (r_n_raw),
        .filt_nxt (filt_r_nxt)
    );

    assign set_req   = ~filt_s_nxt;
    assign reset_req = ~filt_r_nxt;

    always_comb begin
        state_d       = sr_next_state(state_q, set_req, reset_req);
        dec           = sr_decode(state_d);
        q_d           = dec.q;
        q_bar_d       = dec.q_bar;
        invalid_d     = dec.invalid;
        set_pulse_d   = (state_d == HOLD_SET)   && (state_q != HOLD_SET);
        reset_pulse_d = (state_d == HOLD_RESET) && (state_q != HOLD_RESET);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= HOLD_RESET;
            q_q           <= 1'b0;
            q_bar_q       <= 1'b1;
            invalid_q     <= 1'b0;
            set_pulse_q   <= 1'b0;
            reset_pulse_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            q_q           <= q_d;
            q_bar_q       <= q_bar_d;
            invalid_q     <= invalid_d;
            set_pulse_q   <= set_pulse_d;
            reset_pulse_q <= reset_pulse_d;
        end
    end

    assign q           = q_q;
    assign q_bar       = q_bar_q;
    assign invalid     = invalid_q;
    assign set_pulse   = set_pulse_q;
    assign reset_pulse = reset_pulse_q;

endmodule

// File: tb/tb_sr_input_conditioner.sv
// tb/tb_sr_input_conditioner.sv - self-checking bench for sr_input_conditioner
module tb_sr_input_conditioner;

    localparam int D = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic s_n_raw;
    logic r_n_raw;
    logic q, q_bar, set_pulse, reset_pulse, invalid;

    sr_input_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_n_raw     (s_n_raw),
        .r_n_raw     (r_n_raw),
        .q           (q),
        .q_bar       (q_bar),
        .set_pulse   (set_pulse),
        .reset_pulse (reset_pulse),
        .invalid     (invalid)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: 0 = reset held, 1 = set held, 2 = forbidden.
    int         m_state;
    logic       m_fs, m_fr;
    logic [4:0] m_out;
    int         raw_s[$], raw_r[$], syn_s[$], syn_r[$];

    function automatic logic [4:0] dut_out();
        return {q, q_bar, set_pulse, reset_pulse, invalid};
    endfunction

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at t=%0t: got q/qb/sp/rp/inv=%b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        raw_s.delete(); raw_r.delete(); syn_s.delete(); syn_r.delete();
        m_fs = 1'b1; m_fr = 1'b1; m_state = 0; m_out = 5'b01000;
    endtask

    // Filtered level flips only when the last D synchronized samples all disagree with it.
    function automatic logic deb_rule(input int sh[$], input logic f);
        if (sh.size() < D) return f;
        for (int i = 1; i <= D; i++)
            if (sh[sh.size() - i] == int'(f)) return f;
        return ~f;
    endfunction

    task automatic model_edge(input logic s, input logic r);
        int ns;
        raw_s.push_back(int'(s));
        raw_r.push_back(int'(r));
        // Synchronized value seen at this edge is the raw value two edges back.
        syn_s.push_back(raw_s.size() >= 3 ? raw_s[raw_s.size() - 3] : 1);
        syn_r.push_back(raw_r.size() >= 3 ? raw_r[raw_r.size() - 3] : 1);
        while (raw_s.size() > 8) void'(raw_s.pop_front());
        while (raw_r.size() > 8) void'(raw_r.pop_front());
        while (syn_s.size() > 8) void'(syn_s.pop_front());
        while (syn_r.size() > 8) void'(syn_r.pop_front());
        m_fs = deb_rule(syn_s, m_fs);
        m_fr = deb_rule(syn_r, m_fr);
        if (!m_fs && !m_fr)      ns = 2;
        else if (!m_fs)          ns = 1;
        else if (!m_fr)          ns = 0;
        else if (m_state == 2)   ns = 0;
        else                     ns = m_state;
        m_out = {ns != 0, ns != 1, (ns == 1) && (m_state != 1),
                 (ns == 0) && (m_state != 0), ns == 2};
        m_state = ns;
    endtask

    task automatic step(input logic s, input logic r);
        s_n_raw = s;
        r_n_raw = r;
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_edge(s, r);
        #1;
        check("model", dut_out(), m_out);
    endtask

    typedef struct {
        string      name;
        logic       s_n;
        logic       r_n;
        int         cycles;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{"set",               1'b0, 1'b1, 6, 5'b10100};
        vecs[1]  = '{"set_release",       1'b1, 1'b1, 3, 5'b10000};
        vecs[2]  = '{"glitch3",           1'b1, 1'b0, 3, 5'b10000};
        vecs[3]  = '{"glitch3_after",     1'b1, 1'b1, 4, 5'b10000};
        vecs[4]  = '{"reset_long",        1'b1, 1'b0, 6, 5'b01010};
        vecs[5]  = '{"reset_hold",        1'b1, 1'b1, 2, 5'b01000};
        vecs[6]  = '{"forbidden",         1'b0, 1'b0, 6, 5'b11001};
        vecs[7]  = '{"forbidden_release", 1'b1, 1'b1, 6, 5'b01010};
        vecs[8]  = '{"forbidden2",        1'b0, 1'b0, 6, 5'b11001};
        vecs[9]  = '{"forbidden_to_set",  1'b0, 1'b1, 6, 5'b10100};
        vecs[10] = '{"swap_to_reset",     1'b1, 1'b0, 6, 5'b01010};
        vecs[11] = '{"swap_to_set",       1'b0, 1'b1, 6, 5'b10100};

        rst_n   = 1'b0;
        s_n_raw = 1'b0;
        r_n_raw = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold_both_low", dut_out(), 5'b01000);
        s_n_raw = 1'b0; r_n_raw = 1'b1;
        @(posedge clk);
        #1;
        check("reset_hold_set_low", dut_out(), 5'b01000);

        s_n_raw = 1'b1; r_n_raw = 1'b1;
        rst_n   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1);
            check("reset_release", dut_out(), 5'b01000);
        end

        foreach (vecs[i]) begin
            for (int c = 0; c < vecs[i].cycles; c++) step(vecs[i].s_n, vecs[i].r_n);
            check(vecs[i].name, dut_out(), vecs[i].exp);
        end

        // Return to HOLD_RESET, start a set debounce, then reset partway through.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0);
        check("pre_mid_reset", dut_out(), 5'b01000);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("mid_reset_immediate", dut_out(), 5'b01000);
        step(1'b0, 1'b1);
        rst_n = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            step(1'b0, 1'b1);
            check("post_reset_wait", dut_out(), 5'b01000);
        end
        step(1'b0, 1'b1);
        check("post_reset_edge6", dut_out(), 5'b10100);
        step(1'b0, 1'b1);
        check("post_reset_edge7", dut_out(), 5'b10000);
        for (int e = 0; e < 8; e++) step(1'b1, 1'b1);
        check("set_released_holds", dut_out(), 5'b10000);

        // Random run-length stimulus mixes glitches, long holds and async resets.
        for (int run = 0; run < 300; run++) begin
            logic s, r;
            int   len;
            s   = 1'($urandom_range(0, 1));
            r   = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 9);
            for (int c = 0; c < len; c++) step(s, r);
            if ($urandom_range(0, 39) == 0) begin
                rst_n = 1'b0;
                #1;
                model_reset();
                check("async_reset", dut_out(), 5'b01000);
                step(s, r);
                rst_n = 1'b1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
